// File: rtl/adder_tree_acc.sv
// Pipelined signed reduction tree followed by a group accumulator.
// Define ADDER_TREE_ACC_SATURATE_EN to clamp the output to the signed FEATURE_WIDTH range.
module adder_tree_acc #(
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned NUM_IN        = 25,
  parameter int unsigned ACC_DEPTH     = 4,
  localparam int unsigned OUT_WIDTH    = FEATURE_WIDTH + $clog2(NUM_IN) + $clog2(ACC_DEPTH),
  localparam int unsigned CNT_WIDTH    = $clog2(ACC_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [NUM_IN*FEATURE_WIDTH-1:0] in_data,
  input  logic                            acc_clear,
  output logic                            out_valid,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [CNT_WIDTH-1:0]            acc_count
);

  localparam int unsigned S    = $clog2(NUM_IN);
  localparam int unsigned HALF = (NUM_IN + 1) / 2;

  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX =
    {{(OUT_WIDTH-FEATURE_WIDTH+1){1'b0}}, {(FEATURE_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // Number of live operands entering tree level k.
  function automatic int unsigned stage_cnt(input int unsigned k);
    int unsigned n;
    n = NUM_IN;
    for (int unsigned i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic signed [OUT_WIDTH-1:0] r_tree [1:S][HALF];
  logic signed [OUT_WIDTH-1:0] w_lvl  [0:S][NUM_IN+1];
  logic [S:1]                  r_vld;

  logic signed [OUT_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic                        r_out_valid;
  logic signed [OUT_WIDTH-1:0] r_out_data;

  logic signed [OUT_WIDTH-1:0] w_tree_sum;
  logic                        w_tree_vld;
  logic signed [OUT_WIDTH-1:0] w_acc_base;
  logic [CNT_WIDTH-1:0]        w_cnt_base;
  logic signed [OUT_WIDTH-1:0] w_acc_sum;
  logic signed [OUT_WIDTH-1:0] w_final;
  logic                        w_last;

  // Level 0 holds sign-extended inputs; higher levels mirror the stage registers, zero padded.
  always_comb begin
    w_lvl = '{default: '0};
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      w_lvl[0][i] = {{(OUT_WIDTH-FEATURE_WIDTH){in_data[i*FEATURE_WIDTH+FEATURE_WIDTH-1]}},
                     in_data[i*FEATURE_WIDTH +: FEATURE_WIDTH]};
    end
    for (int unsigned k = 1; k <= S; k++) begin
      for (int unsigned j = 0; j < HALF; j++) begin
        w_lvl[k][j] = r_tree[k][j];
      end
    end
  end

  // Tree data stages load every cycle; an odd leftover is passed through unchanged.
  always_ff @(posedge clk) begin
    for (int unsigned k = 1; k <= S; k++) begin
      for (int unsigned j = 0; j < HALF; j++) begin
        if (2*j + 1 < stage_cnt(k - 1)) begin
          r_tree[k][j] <= w_lvl[k-1][2*j] + w_lvl[k-1][2*j+1];
        end else if (2*j < stage_cnt(k - 1)) begin
          r_tree[k][j] <= w_lvl[k-1][2*j];
        end else begin
          r_tree[k][j] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[1] <= in_valid;
      for (int unsigned k = 2; k <= S; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  // A clear coinciding with a tree result makes that result the first of a new group.
  always_comb begin
    w_tree_sum = w_lvl[S][0];
    w_tree_vld = r_vld[S];
    w_acc_base = acc_clear ? '0 : r_acc;
    w_cnt_base = acc_clear ? '0 : r_cnt;
    w_acc_sum  = w_acc_base + w_tree_sum;
    w_last     = (w_cnt_base == CNT_WIDTH'(ACC_DEPTH - 1));
`ifdef ADDER_TREE_ACC_SATURATE_EN
    if (w_acc_sum > SAT_MAX) begin
      w_final = SAT_MAX;
    end else if (w_acc_sum < SAT_MIN) begin
      w_final = SAT_MIN;
    end else begin
      w_final = w_acc_sum;
    end
`else
    w_final = w_acc_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_tree_vld) begin
        if (w_last) begin
          r_out_data  <= w_final;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= w_cnt_base + CNT_WIDTH'(1);
        end
      end else if (acc_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign acc_count = r_cnt;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed scoreboard bench for adder_tree_acc (25-input/depth-4 and 7-input/depth-1 instances).
module tb_adder_tree_acc;

  localparam int unsigned FW    = 16;
  localparam int unsigned NI    = 25;
  localparam int unsigned AD    = 4;
  localparam int unsigned S     = $clog2(NI);
  localparam int unsigned LAT   = S + 1;
  localparam int unsigned OUT_W = FW + $clog2(NI) + $clog2(AD);
  localparam int unsigned CW    = $clog2(AD + 1);
  localparam int unsigned NI7   = 7;
  localparam int unsigned OUT_W7 = FW + $clog2(NI7);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic [NI*FW-1:0]         in_data;
  logic                     acc_clear;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic [CW-1:0]            acc_count;

  logic                     in_valid7;
  logic [NI7*FW-1:0]        in_data7;
  logic                     acc_clear7;
  logic                     out_valid7;
  logic signed [OUT_W7-1:0] out_data7;
  logic [0:0]               acc_count7;

  adder_tree_acc #(.FEATURE_WIDTH(FW), .NUM_IN(NI), .ACC_DEPTH(AD)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_data(out_data), .acc_count(acc_count)
  );

  adder_tree_acc #(.FEATURE_WIDTH(FW), .NUM_IN(NI7), .ACC_DEPTH(1)) u_dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid7), .in_data(in_data7), .acc_clear(acc_clear7),
    .out_valid(out_valid7), .out_data(out_data7), .acc_count(acc_count7)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  exp_t   sb[$];
  int     checks   = 0;
  int     failures = 0;
  bit     mon_en   = 1'b0;
  longint m_acc    = 0;
  int     m_cnt    = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic longint exp_final(input longint v);
`ifdef ADDER_TREE_ACC_SATURATE_EN
    longint hi;
    hi = (longint'(1) << (FW - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
`endif
    return v;
  endfunction

  // One beat with every element equal to v; the model predicts the group result.
  task automatic beat(input logic [FW-1:0] v);
    longint sum;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) in_data[i*FW +: FW] = v;
    in_valid  = 1'b1;
    acc_clear = 1'b0;
    sum = longint'(NI) * longint'($signed(v));
    if (m_cnt == AD - 1) begin
      sb.push_back('{exp_final(m_acc + sum), cyc + LAT});
      m_acc = 0;
      m_cnt = 0;
    end else begin
      m_acc = m_acc + sum;
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      acc_clear = 1'b0;
    end
  endtask

  task automatic clear_now();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    acc_clear = 1'b1;
  endtask

  // Every cycle, out_valid must match the scoreboard head's due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_vld;
      exp_t e;
      exp_vld = (sb.size() != 0) && (sb[0].due == cyc);
      check("out_valid", 64'(out_valid), 64'(exp_vld));
      if (exp_vld) begin
        e = sb.pop_front();
        check("out_data", out_data, e.val);
      end
    end
  end

  initial begin
    int t0;
    rst = 1'b1; in_valid = 1'b0; acc_clear = 1'b0; in_data = '0;
    in_valid7 = 1'b0; acc_clear7 = 1'b0; in_data7 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_acc_count", 64'(acc_count), 0);
    check("rst_out_valid7", 64'(out_valid7), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // all ones, back to back
    repeat (4) beat(FW'(1));
    idle(10);
    check("acc_count_after_group", 64'(acc_count), 64'(m_cnt));

    // all -1
    repeat (4) beat(16'hFFFF);
    idle(10);

    // bubbles inside a group
    repeat (2) beat(FW'(2));
    idle(3);
    repeat (2) beat(FW'(2));
    idle(10);

    // partial group discarded by acc_clear
    repeat (2) beat(FW'(1));
    idle(10);
    check("acc_count_partial", 64'(acc_count), 64'(m_cnt));
    clear_now();
    m_acc = 0;
    m_cnt = 0;
    @(negedge clk);
    check("acc_count_clear_pending", 64'(acc_count), 2);
    @(posedge clk); #1;
    acc_clear = 1'b0;
    check("acc_count_cleared", 64'(acc_count), 0);
    repeat (4) beat(FW'(3));
    idle(10);

    // extremes
    repeat (4) beat(16'h7FFF);
    idle(10);
    repeat (4) beat(16'h8000);
    idle(10);

    // clear coinciding with a valid tree result: that result opens the new group
    beat(FW'(1));
    beat(FW'(5));
    idle(4);
    clear_now();
    m_acc = longint'(NI) * 5;
    m_cnt = 1;
    idle(3);
    check("acc_count_coincident_clear", 64'(acc_count), 1);
    repeat (3) beat(FW'(2));
    idle(10);

    // reset three beats into a group
    repeat (3) beat(FW'(1));
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    sb.delete();
    m_acc = 0;
    m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_data", out_data, 0);
    check("midrst_acc_count", 64'(acc_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);
    check("postrst_acc_count", 64'(acc_count), 0);
    repeat (4) beat(FW'(1));
    idle(10);

    // 7-input, depth-1 instance: two consecutive beats, pulses 4 cycles after each
    @(posedge clk); #1;
    for (int i = 0; i < NI7; i++) in_data7[i*FW +: FW] = FW'(i + 1);
    in_valid7 = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    for (int i = 0; i < NI7; i++) in_data7[i*FW +: FW] = FW'(-(i + 1));
    @(posedge clk); #1;
    in_valid7 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("out_valid7", 64'(out_valid7), 64'((cyc == t0 + 4) || (cyc == t0 + 5)));
      check("acc_count7", 64'(acc_count7), 0);
      if (cyc == t0 + 4) check("out_data7_pos", out_data7, 28);
      if (cyc == t0 + 5) check("out_data7_neg", out_data7, -28);
    end

    check("scoreboard_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
